rv_load_store_unit: RTL and testbench

//  Data-memory access stage between execute and writeback. Takes load/store requests from

---
 rtl/rv_load_store_unit_pkg.sv | 36 +++
 rtl/rv_lsu_store_align.sv | 37 +++
 rtl/rv_load_store_unit.sv | 175 +++++++++++++++++
 tb/tb_rv_load_store_unit.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/rv_load_store_unit_pkg.sv
// Shared load/store definitions: LDST function codes (also used by writeback),
// LSU FSM state encoding, default bus timeout and an access-size helper.
package rv_load_store_unit_pkg;

  localparam logic [2:0] LDST_B  = 3'b000;
  localparam logic [2:0] LDST_H  = 3'b001;
  localparam logic [2:0] LDST_L  = 3'b010;
  localparam logic [2:0] LDST_BU = 3'b100;
  localparam logic [2:0] LDST_HU = 3'b101;

  localparam int unsigned LSU_TIMEOUT_DEFAULT = 255;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_BUSY = 2'd1,
    LSU_DONE = 2'd2
  } lsu_state_e;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } ldst_size_e;

  // Unknown function codes are treated as full-word accesses.
  function automatic ldst_size_e ldst_size(input logic [2:0] fun);
    ldst_size_e sz;
    case (fun)
      LDST_B, LDST_BU: sz = SZ_BYTE;
      LDST_H, LDST_HU: sz = SZ_HALF;
      default:         sz = SZ_WORD;
    endcase
    return sz;
  endfunction

endpackage

// File: rtl/rv_lsu_store_align.sv
// Combinational store lane steering: replicates store data across byte lanes,
// builds byte enables and flags accesses that are not naturally aligned.
module rv_lsu_store_align
  import rv_load_store_unit_pkg::*;
(
  input  logic        is_store_i,
  input  logic [2:0]  fun_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic [3:0]  sel_o,
  output logic        misaligned_o
);

  always_comb begin
    data_o       = is_store_i ? data_i : '0;
    sel_o        = 4'b1111;
    misaligned_o = 1'b0;
    case (ldst_size(fun_i))
      SZ_BYTE: begin
        if (is_store_i) begin
          sel_o  = 4'b0001 << addr_lo_i;
          data_o = {4{data_i[7:0]}};
        end
      end
      SZ_HALF: begin
        misaligned_o = addr_lo_i[0];
        if (is_store_i) begin
          sel_o  = addr_lo_i[1] ? 4'b1100 : 4'b0011;
          data_o = {2{data_i[15:0]}};
        end
      end
      default: misaligned_o = |addr_lo_i;
    endcase
  end

endmodule

// File: rtl/rv_load_store_unit.sv
// Data-memory access stage: single-outstanding bus master with timeout abort.
// Define URV_LSU_MISALIGN_TRAP_EN to complete misaligned H/HU/L accesses without a bus cycle.
module rv_load_store_unit
  import rv_load_store_unit_pkg::*;
#(
  parameter int unsigned g_timeout = LSU_TIMEOUT_DEFAULT
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        w_stall_i,
  input  logic        x_load_i,
  input  logic        x_store_i,
  input  logic [2:0]  x_fun_i,
  input  logic [31:0] x_dm_addr_i,
  input  logic [31:0] x_dm_store_value_i,
  output logic [31:0] dm_addr_o,
  output logic [31:0] dm_data_s_o,
  output logic [3:0]  dm_data_select_o,
  output logic        dm_load_o,
  output logic        dm_store_o,
  input  logic        dm_ready_i,
  input  logic [31:0] dm_data_l_i,
  output logic [31:0] wb_data_l_o,
  output logic        wb_load_done_o,
  output logic        wb_store_done_o,
  output logic        bus_err_o,
  output logic        misaligned_o
);

`ifdef URV_LSU_MISALIGN_TRAP_EN
  localparam bit TrapEn = 1'b1;
`else
  localparam bit TrapEn = 1'b0;
`endif

  lsu_state_e  state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] data_s_q, data_s_d;
  logic [3:0]  sel_q, sel_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic        ld_q, ld_d, st_q, st_d;
  logic        ld_done_q, ld_done_d, st_done_q, st_done_d;
  logic        err_q, err_d, mis_q, mis_d;

  logic        is_load;
  logic [31:0] al_data;
  logic [3:0]  al_sel;
  logic        al_mis;
  logic        trap;
  logic        timeout_hit;

  // Load has priority when execute raises both requests.
  assign is_load = x_load_i;

  rv_lsu_store_align u_align (
    .is_store_i   (!is_load),
    .fun_i        (x_fun_i),
    .addr_lo_i    (x_dm_addr_i[1:0]),
    .data_i       (x_dm_store_value_i),
    .data_o       (al_data),
    .sel_o        (al_sel),
    .misaligned_o (al_mis)
  );

  assign trap        = TrapEn & al_mis;
  assign timeout_hit = (g_timeout != 0) && (cnt_q == g_timeout - 1);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    data_s_d  = data_s_q;
    sel_d     = sel_q;
    wb_data_d = wb_data_q;
    ld_d      = ld_q;
    st_d      = st_q;
    ld_done_d = ld_done_q;
    st_done_d = st_done_q;
    err_d     = err_q;
    mis_d     = mis_q;
    case (state_q)
      LSU_IDLE: begin
        if (x_load_i | x_store_i) begin
          addr_d   = {x_dm_addr_i[31:2], 2'b00};
          data_s_d = al_data;
          sel_d    = al_sel;
          cnt_d    = '0;
          if (trap) begin
            state_d   = LSU_DONE;
            ld_done_d = is_load;
            st_done_d = !is_load;
            mis_d     = 1'b1;
            err_d     = 1'b0;
            wb_data_d = '0;
          end else begin
            state_d = LSU_BUSY;
            ld_d    = is_load;
            st_d    = !is_load;
          end
        end
      end
      LSU_BUSY: begin
        if (dm_ready_i || timeout_hit) begin
          state_d   = LSU_DONE;
          ld_d      = 1'b0;
          st_d      = 1'b0;
          ld_done_d = ld_q;
          st_done_d = st_q;
          // A ready arriving on the timeout cycle still completes normally.
          if (dm_ready_i) begin
            if (ld_q) wb_data_d = dm_data_l_i;
          end else begin
            err_d     = 1'b1;
            wb_data_d = '0;
          end
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      LSU_DONE: begin
        if (!w_stall_i) begin
          state_d   = LSU_IDLE;
          ld_done_d = 1'b0;
          st_done_d = 1'b0;
          err_d     = 1'b0;
          mis_d     = 1'b0;
        end
      end
      default: state_d = LSU_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= LSU_IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      data_s_q  <= '0;
      sel_q     <= '0;
      wb_data_q <= '0;
      ld_q      <= 1'b0;
      st_q      <= 1'b0;
      ld_done_q <= 1'b0;
      st_done_q <= 1'b0;
      err_q     <= 1'b0;
      mis_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      data_s_q  <= data_s_d;
      sel_q     <= sel_d;
      wb_data_q <= wb_data_d;
      ld_q      <= ld_d;
      st_q      <= st_d;
      ld_done_q <= ld_done_d;
      st_done_q <= st_done_d;
      err_q     <= err_d;
      mis_q     <= mis_d;
    end
  end

  assign dm_addr_o        = addr_q;
  assign dm_data_s_o      = data_s_q;
  assign dm_data_select_o = sel_q;
  assign dm_load_o        = ld_q;
  assign dm_store_o       = st_q;
  assign wb_data_l_o      = wb_data_q;
  assign wb_load_done_o   = ld_done_q;
  assign wb_store_done_o  = st_done_q;
  assign bus_err_o        = err_q;
  assign misaligned_o     = mis_q;

endmodule

// File: tb/tb_rv_load_store_unit.sv
// Self-checking bench for rv_load_store_unit: directed scenarios then randomized
// accesses checked against an arithmetic reference model.
module tb_rv_load_store_unit;
  import rv_load_store_unit_pkg::*;

  localparam int G_TO = 8;
`ifdef URV_LSU_MISALIGN_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n_i = 1'b0;
  logic        w_stall_i = 1'b0;
  logic        x_load_i = 1'b0;
  logic        x_store_i = 1'b0;
  logic [2:0]  x_fun_i = 3'b0;
  logic [31:0] x_dm_addr_i = '0;
  logic [31:0] x_dm_store_value_i = '0;
  logic [31:0] dm_addr_o, dm_data_s_o, wb_data_l_o;
  logic [3:0]  dm_data_select_o;
  logic        dm_load_o, dm_store_o;
  logic        dm_ready_i = 1'b0;
  logic [31:0] dm_data_l_i = '0;
  logic        wb_load_done_o, wb_store_done_o, bus_err_o, misaligned_o;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  rv_load_store_unit #(.g_timeout(G_TO)) dut (
    .clk_i              (clk),
    .rst_n_i            (rst_n_i),
    .w_stall_i          (w_stall_i),
    .x_load_i           (x_load_i),
    .x_store_i          (x_store_i),
    .x_fun_i            (x_fun_i),
    .x_dm_addr_i        (x_dm_addr_i),
    .x_dm_store_value_i (x_dm_store_value_i),
    .dm_addr_o          (dm_addr_o),
    .dm_data_s_o        (dm_data_s_o),
    .dm_data_select_o   (dm_data_select_o),
    .dm_load_o          (dm_load_o),
    .dm_store_o         (dm_store_o),
    .dm_ready_i         (dm_ready_i),
    .dm_data_l_i        (dm_data_l_i),
    .wb_data_l_o        (wb_data_l_o),
    .wb_load_done_o     (wb_load_done_o),
    .wb_store_done_o    (wb_store_done_o),
    .bus_err_o          (bus_err_o),
    .misaligned_o       (misaligned_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: access size in bytes, lane position, replication by multiplication.
  task automatic model(input bit ld, input logic [2:0] fun, input logic [31:0] a,
                       input logic [31:0] d, output logic [3:0] sel,
                       output logic [31:0] sd, output bit mis);
    int nbytes;
    int ofs;
    nbytes = (fun == LDST_B || fun == LDST_BU) ? 1 :
             (fun == LDST_H || fun == LDST_HU) ? 2 : 4;
    ofs = int'(a[1:0]);
    mis = (ofs % nbytes) != 0;
    if (ld || nbytes == 4) begin
      sel = 4'hF;
      sd  = d;
    end else if (nbytes == 1) begin
      sel = 4'(1 << ofs);
      sd  = {24'd0, d[7:0]} * 32'h0101_0101;
    end else begin
      sel = 4'(3 << ((ofs / 2) * 2));
      sd  = {16'd0, d[15:0]} * 32'h0001_0001;
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_ld_strobe"}, 32'(dm_load_o), 32'd0);
    check({tag, "_st_strobe"}, 32'(dm_store_o), 32'd0);
    check({tag, "_ld_done"}, 32'(wb_load_done_o), 32'd0);
    check({tag, "_st_done"}, 32'(wb_store_done_o), 32'd0);
    check({tag, "_bus_err"}, 32'(bus_err_o), 32'd0);
    check({tag, "_misaligned"}, 32'(misaligned_o), 32'd0);
  endtask

  // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle.
  // rdy_dly: index of the BUSY cycle carrying dm_ready_i (>= G_TO means never).
  task automatic do_access(input bit ld, input bit both, input logic [2:0] fun,
                           input logic [31:0] a, input logic [31:0] d,
                           input int rdy_dly, input logic [31:0] rd, input int stall);
    logic [3:0]  esel;
    logic [31:0] esd;
    bit          mis, trap, err;
    int          busy_cycles;
    model(ld, fun, a, d, esel, esd, mis);
    trap = TRAP_EN && mis;
    err  = !trap;
    busy_cycles = 0;
    x_load_i = ld;
    x_store_i = !ld || both;
    x_fun_i = fun;
    x_dm_addr_i = a;
    x_dm_store_value_i = d;
    dm_ready_i = 1'b0;
    @(negedge clk);
    x_load_i = 1'b0;
    x_store_i = 1'b0;
    if (!trap) begin
      for (int k = 0; k < G_TO; k++) begin
        busy_cycles++;
        check("busy_ld_strobe", 32'(dm_load_o), 32'(ld));
        check("busy_st_strobe", 32'(dm_store_o), 32'(!ld));
        if (k == 0) begin
          check("bus_addr", dm_addr_o, {a[31:2], 2'b00});
          check("bus_sel", 32'(dm_data_select_o), 32'(esel));
          if (!ld) check("bus_sdata", dm_data_s_o, esd);
        end
        if (k == rdy_dly) begin
          dm_ready_i = 1'b1;
          dm_data_l_i = rd;
          err = 1'b0;
        end else begin
          dm_ready_i = 1'b0;
          dm_data_l_i = $urandom;
        end
        @(negedge clk);
        if (!err) break;
      end
    end
    for (int s = 0; s <= stall; s++) begin
      check("done_ld", 32'(wb_load_done_o), 32'(ld));
      check("done_st", 32'(wb_store_done_o), 32'(!ld));
      check("done_err", 32'(bus_err_o), 32'(err));
      check("done_mis", 32'(misaligned_o), 32'(trap));
      check("done_ld_strobe", 32'(dm_load_o), 32'd0);
      check("done_st_strobe", 32'(dm_store_o), 32'd0);
      if (ld) check("done_data", wb_data_l_o, (trap || err) ? 32'd0 : rd);
      // Late acks and new requests must be ignored while done is presented.
      dm_ready_i = 1'($urandom);
      dm_data_l_i = $urandom;
      w_stall_i = (s < stall);
      x_store_i = (s < stall);
      @(negedge clk);
    end
    w_stall_i = 1'b0;
    x_store_i = 1'b0;
    dm_ready_i = 1'b0;
    check_idle("post_done");
    $display("[TB] txn %s fun=%0d addr=%h wdata=%h rdy_dly=%0d busy=%0d stall=%0d trap=%0b err=%0b",
             ld ? "LOAD " : "STORE", fun, a, d, rdy_dly, busy_cycles, stall, trap, err);
  endtask

  initial begin
    logic [2:0] ld_funs [5];
    logic [2:0] st_funs [3];
    ld_funs = '{LDST_B, LDST_BU, LDST_H, LDST_HU, LDST_L};
    st_funs = '{LDST_B, LDST_H, LDST_L};

    // Reset state
    @(negedge clk);
    check_idle("reset");
    check("reset_sel", 32'(dm_data_select_o), 32'd0);
    check("reset_addr", dm_addr_o, 32'd0);
    check("reset_wbdata", wb_data_l_o, 32'd0);
    @(negedge clk);
    rst_n_i = 1'b1;
    @(negedge clk);

    // Directed scenarios
    do_access(1'b0, 1'b0, LDST_B, 32'h0000_1003, 32'h0000_00A5, 0, 32'h0, 0);
    do_access(1'b1, 1'b0, LDST_L, 32'h0000_2000, 32'h0, 3, 32'h1234_5678, 0);
    do_access(1'b1, 1'b0, LDST_H, 32'h0000_2002, 32'h0, 1, 32'hCAFE_BEEF, 4);
    do_access(1'b1, 1'b0, LDST_L, 32'h0000_2004, 32'h0, 100, 32'h0, 2);
    do_access(1'b1, 1'b1, LDST_L, 32'h0000_2008, 32'h5555_AAAA, 7, 32'h0BAD_F00D, 0);
    do_access(1'b1, 1'b0, LDST_L, 32'h0000_3002, 32'h0, 0, 32'h8765_4321, 0);

    // Reset in the middle of a bus access
    x_load_i = 1'b1;
    x_fun_i = LDST_L;
    x_dm_addr_i = 32'h0000_4000;
    @(negedge clk);
    x_load_i = 1'b0;
    check("pre_rst_ld_strobe", 32'(dm_load_o), 32'd1);
    #2 rst_n_i = 1'b0;
    #1;
    check("rst_ld_strobe", 32'(dm_load_o), 32'd0);
    check("rst_st_strobe", 32'(dm_store_o), 32'd0);
    @(negedge clk);
    rst_n_i = 1'b1;
    @(negedge clk);
    check_idle("after_rst");
    do_access(1'b0, 1'b0, LDST_L, 32'h0000_4004, 32'hDEAD_BEEF, 0, 32'h0, 0);

    // Randomized accesses
    for (int t = 0; t < 40; t++) begin
      bit          ld;
      logic [2:0]  fun;
      int          dly;
      ld  = 1'($urandom);
      fun = ld ? ld_funs[$urandom_range(4, 0)] : st_funs[$urandom_range(2, 0)];
      dly = ($urandom_range(9, 0) == 0) ? G_TO + 3 : int'($urandom_range(3, 0));
      do_access(ld, ld && ($urandom_range(3, 0) == 0), fun, $urandom, $urandom,
                dly, $urandom, int'($urandom_range(2, 0)));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
